// File: rtl/adc_scan_sequencer.sv
// Multi-channel scan sequencer: steps the analog mux over enabled channels, starts the ADC, tags results.
// Optional per-channel averaging is enabled by defining ADC_SCAN_AVG_EN.
module adc_scan_sequencer #(
  parameter int NUM_CH         = 4,
  parameter int CH_W           = 2,
  parameter int SETTLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int AVG_LOG2       = 2
) (
  input  logic              hs_clk,
  input  logic              sys_rst_n,
  input  logic              scan_en,
  input  logic              single_shot,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              err_clr,
  output logic [CH_W-1:0]   mux_sel,
  output logic              mux_valid,
  output logic              adc_start,
  input  logic              adc_ready,
  input  logic              ad_data_valid,
  input  logic [7:0]        ad_data_in,
  input  logic              ad_error,
  output logic [7:0]        smp_data,
  output logic [CH_W-1:0]   smp_ch,
  output logic              smp_err,
  output logic              smp_valid,
  input  logic              smp_ready,
  output logic              busy,
  output logic              scan_done,
  output logic              timeout_err
);

`ifdef ADC_SCAN_AVG_EN
  localparam int NAVG = AVG_LOG2;
`else
  localparam int NAVG = 0;
`endif
  localparam int ACC_W = 8 + NAVG;
  localparam int SW    = $clog2(SETTLE_CYCLES + 1);
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [NAVG:0] AVG_LAST = (NAVG+1)'((1 << NAVG) - 1);

  if (NUM_CH < 2 || NUM_CH > 16 || (1 << CH_W) < NUM_CH || SETTLE_CYCLES < 1 ||
      TIMEOUT_CYCLES < 6 || AVG_LOG2 < 0 || AVG_LOG2 > 8) begin : g_param_err
    $error("adc_scan_sequencer: illegal parameter set");
  end

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_START, S_CONVERT, S_OUTPUT, S_NEXT} state_t;

  state_t             state, state_n;
  logic [CH_W-1:0]    mux_sel_n;
  logic [NUM_CH-1:0]  mask_q, mask_n, above;
  logic               cont_q, cont_n;
  logic [SW-1:0]      settle_cnt, settle_n;
  logic [TW-1:0]      tmo_cnt, tmo_n;
  logic [NAVG:0]      avg_cnt, avg_n;
  logic [ACC_W-1:0]   acc_q, acc_n, sum;
  logic               err_acc, err_acc_n, eacc;
  logic [7:0]         sdata_q, sdata_n, samp;
  logic               serr_q, serr_n, samp_err;
  logic               tmo_set, has_next;

  function automatic logic [CH_W-1:0] lowest(input logic [NUM_CH-1:0] m);
    lowest = '0;
    for (int i = NUM_CH-1; i >= 0; i--)
      if (m[i]) lowest = CH_W'(i);
  endfunction

  always_comb begin
    above = '0;
    for (int i = 0; i < NUM_CH; i++)
      above[i] = mask_q[i] && (i > int'(mux_sel));
  end
  assign has_next = |above;

  always_comb begin
    state_n   = state;
    mux_sel_n = mux_sel;
    mask_n    = mask_q;
    cont_n    = cont_q;
    settle_n  = '0;
    tmo_n     = '0;
    avg_n     = avg_cnt;
    acc_n     = acc_q;
    err_acc_n = err_acc;
    sdata_n   = sdata_q;
    serr_n    = serr_q;
    samp      = ad_data_in;
    samp_err  = ad_error;
    sum       = '0;
    eacc      = 1'b0;
    tmo_set   = 1'b0;
    adc_start = 1'b0;
    scan_done = 1'b0;
    case (state)
      S_IDLE:
        if ((scan_en || single_shot) && |ch_mask) begin
          mask_n    = ch_mask;
          cont_n    = scan_en;
          mux_sel_n = lowest(ch_mask);
          state_n   = S_SETTLE;
        end
      S_SETTLE: begin
        settle_n  = settle_cnt + 1'b1;
        avg_n     = '0;
        acc_n     = '0;
        err_acc_n = 1'b0;
        if (settle_cnt == SW'(SETTLE_CYCLES - 1)) state_n = S_START;
      end
      S_START:
        if (adc_ready) begin
          adc_start = 1'b1;
          state_n   = S_CONVERT;
        end
      S_CONVERT: begin
        tmo_n = tmo_cnt + 1'b1;
        if (ad_data_valid || tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          // a timed-out conversion counts as a zero-valued, errored result
          samp     = ad_data_valid ? ad_data_in : 8'h00;
          samp_err = ad_data_valid ? ad_error : 1'b1;
          tmo_set  = !ad_data_valid;
          sum      = acc_q + ACC_W'(samp);
          eacc     = err_acc | samp_err;
          if (avg_cnt == AVG_LAST) begin
            sdata_n = sum[NAVG +: 8];
            serr_n  = eacc;
            state_n = S_OUTPUT;
          end else begin
            acc_n     = sum;
            err_acc_n = eacc;
            avg_n     = avg_cnt + 1'b1;
            state_n   = S_START;
          end
        end
      end
      S_OUTPUT:
        if (smp_ready) state_n = (cont_q && !scan_en) ? S_IDLE : S_NEXT;
      S_NEXT:
        if (has_next) begin
          mux_sel_n = lowest(above);
          state_n   = S_SETTLE;
        end else begin
          scan_done = 1'b1;
          if (cont_q && scan_en && |ch_mask) begin
            mask_n    = ch_mask;
            mux_sel_n = lowest(ch_mask);
            state_n   = S_SETTLE;
          end else begin
            state_n = S_IDLE;
          end
        end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge hs_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= S_IDLE;
      mux_sel     <= '0;
      mask_q      <= '0;
      cont_q      <= 1'b0;
      settle_cnt  <= '0;
      tmo_cnt     <= '0;
      avg_cnt     <= '0;
      acc_q       <= '0;
      err_acc     <= 1'b0;
      sdata_q     <= '0;
      serr_q      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      mux_sel     <= mux_sel_n;
      mask_q      <= mask_n;
      cont_q      <= cont_n;
      settle_cnt  <= settle_n;
      tmo_cnt     <= tmo_n;
      avg_cnt     <= avg_n;
      acc_q       <= acc_n;
      err_acc     <= err_acc_n;
      sdata_q     <= sdata_n;
      serr_q      <= serr_n;
      // clear wins over a timeout landing in the same cycle
      timeout_err <= err_clr ? 1'b0 : (timeout_err | tmo_set);
    end
  end

  assign busy      = (state != S_IDLE);
  assign mux_valid = (state == S_START) || (state == S_CONVERT) || (state == S_OUTPUT);
  assign smp_valid = (state == S_OUTPUT);
  assign smp_data  = sdata_q;
  assign smp_err   = serr_q;
  assign smp_ch    = mux_sel;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed bench for adc_scan_sequencer with a 4-cycle ADC model; averaging case runs under ADC_SCAN_AVG_EN.
module tb_adc_scan_sequencer;
  localparam int NUM_CH = 4, CH_W = 2, SETTLE = 8, TMO = 16, AVGL = 2;

  logic hs_clk = 1'b0, sys_rst_n;
  logic scan_en, single_shot, err_clr, adc_ready, smp_ready;
  logic [NUM_CH-1:0] ch_mask;
  logic [CH_W-1:0] mux_sel, smp_ch;
  logic mux_valid, adc_start, ad_data_valid, ad_error, smp_err, smp_valid, busy, scan_done, timeout_err;
  logic [7:0] ad_data_in, smp_data;

  int n_cmp = 0, n_bad = 0, n_start = 0, n_done = 0;
  int samples[$];
  logic no_strobe = 1'b0, stray = 1'b0, avg_mode = 1'b0;
  int conv_idx = 0;
  logic [7:0] avg_vals [4] = '{8'd10, 8'd11, 8'd12, 8'd13};
  logic [4:0] vpipe = '0, epipe = '0;
  logic [4:0][7:0] dpipe = '0;

  adc_scan_sequencer #(.NUM_CH(NUM_CH), .CH_W(CH_W), .SETTLE_CYCLES(SETTLE),
                       .TIMEOUT_CYCLES(TMO), .AVG_LOG2(AVGL)) dut (
    .hs_clk(hs_clk), .sys_rst_n(sys_rst_n), .scan_en(scan_en), .single_shot(single_shot),
    .ch_mask(ch_mask), .err_clr(err_clr), .mux_sel(mux_sel), .mux_valid(mux_valid),
    .adc_start(adc_start), .adc_ready(adc_ready), .ad_data_valid(ad_data_valid),
    .ad_data_in(ad_data_in), .ad_error(ad_error), .smp_data(smp_data), .smp_ch(smp_ch),
    .smp_err(smp_err), .smp_valid(smp_valid), .smp_ready(smp_ready), .busy(busy),
    .scan_done(scan_done), .timeout_err(timeout_err));

  always #5 hs_clk = ~hs_clk;

  // ADC model: result strobe 4 cycles after the adc_start cycle, data = ch*16+3
  always @(negedge hs_clk) begin
    logic [7:0] d;
    logic e;
    d = avg_mode ? avg_vals[conv_idx[1:0]] : {2'b00, mux_sel, 4'h3};
    e = avg_mode && (conv_idx == 2);
    if (adc_start && avg_mode) conv_idx++;
    vpipe = {vpipe[3:0], adc_start && !no_strobe};
    dpipe = {dpipe[3:0], d};
    epipe = {epipe[3:0], e};
  end
  assign ad_data_valid = vpipe[4] | stray;
  assign ad_data_in    = dpipe[4];
  assign ad_error      = epipe[4] & vpipe[4];

  always @(negedge hs_clk) begin
    if (adc_start) n_start++;
    if (scan_done) n_done++;
    if (smp_valid && smp_ready)
      samples.push_back((int'(smp_err) << 12) | (int'(smp_ch) << 8) | int'(smp_data));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin @(negedge hs_clk); n++; end
    chk("idle_wait", busy, 0);
  endtask

  task automatic wait_start(input int budget);
    int n = 0;
    while (!adc_start && n < budget) begin @(negedge hs_clk); n++; end
    chk("start_wait", adc_start, 1);
  endtask

  task automatic pulse_single();
    single_shot = 1'b1;
    @(negedge hs_clk);
    single_shot = 1'b0;
  endtask

  initial begin
    int s0, d0, st0, lat, nbad;
    sys_rst_n = 1'b0; scan_en = 0; single_shot = 0; ch_mask = '0; err_clr = 0;
    adc_ready = 1'b1; smp_ready = 1'b0;
    repeat (3) @(negedge hs_clk);
    chk("rst_busy", busy, 0);
    chk("rst_mux_sel", mux_sel, 0);
    chk("rst_outs", {mux_valid, adc_start, smp_valid, scan_done, timeout_err, smp_err}, 0);
    chk("rst_data", smp_data, 0);
    sys_rst_n = 1'b1;
    @(negedge hs_clk);

    // 1: single scan over ch1/ch3; mask change mid-scan must be ignored
    ch_mask = 4'b1010; smp_ready = 1'b1; s0 = samples.size(); d0 = n_done;
    pulse_single();
    chk("t1_busy", busy, 1);
    chk("t1_first_ch", mux_sel, 1);
    ch_mask = 4'b0001;
    lat = 1;
    while (!smp_valid && lat < 300) begin @(negedge hs_clk); lat++; end
`ifndef ADC_SCAN_AVG_EN
    chk("t1_latency", lat, SETTLE + 1 + 4 + 1);
`endif
    wait_idle(400);
    chk("t1_count", samples.size() - s0, 2);
    chk("t1_smp0", samples[s0], 32'h0113);
    chk("t1_smp1", samples[s0+1], 32'h0333);
    chk("t1_done", n_done - d0, 1);

    // 2: empty mask never starts; stray strobe ignored
    ch_mask = '0; scan_en = 1'b1; st0 = n_start; s0 = samples.size(); nbad = 0;
    stray = 1'b1;
    @(negedge hs_clk);
    stray = 1'b0;
    repeat (99) begin @(negedge hs_clk); if (busy) nbad++; end
    chk("t2_no_start", n_start - st0, 0);
    chk("t2_busy_cycles", nbad, 0);
    chk("t2_no_smp", samples.size() - s0, 0);
    scan_en = 1'b0;

    // 3: 50-cycle stall on the first sample
    ch_mask = 4'b1010; smp_ready = 1'b0; s0 = samples.size();
    pulse_single();
    lat = 0;
    while (!smp_valid && lat < 300) begin @(negedge hs_clk); lat++; end
    chk("t3_valid", smp_valid, 1);
    chk("t3_ch", smp_ch, 1);
    chk("t3_data", smp_data, 8'h13);
    st0 = n_start; nbad = 0;
    repeat (50) begin
      @(negedge hs_clk);
      if (!smp_valid || smp_ch !== 2'd1 || smp_data !== 8'h13 || adc_start) nbad++;
    end
    chk("t3_hold", nbad, 0);
    chk("t3_no_start", n_start - st0, 0);
    smp_ready = 1'b1;
    wait_idle(400);
    chk("t3_count", samples.size() - s0, 2);
    chk("t3_smp1", samples[s0+1], 32'h0333);

    // 4: timeout on ch0, err_clr, scan continues on ch1
    ch_mask = 4'b0011; smp_ready = 1'b0; no_strobe = 1'b1; s0 = samples.size();
    pulse_single();
    wait_start(100);
    lat = 0;
    while (!smp_valid && lat < 300) begin @(negedge hs_clk); lat++; end
`ifndef ADC_SCAN_AVG_EN
    chk("t4_tmo_latency", lat, TMO + 1);
`endif
    chk("t4_data", smp_data, 8'h00);
    chk("t4_err", smp_err, 1);
    chk("t4_sticky", timeout_err, 1);
    no_strobe = 1'b0; err_clr = 1'b1;
    @(negedge hs_clk);
    err_clr = 1'b0;
    chk("t4_clr", timeout_err, 0);
    smp_ready = 1'b1;
    wait_idle(400);
    chk("t4_count", samples.size() - s0, 2);
    chk("t4_smp0", samples[s0], 32'h1000);
    chk("t4_smp1", samples[s0+1], 32'h0113);

    // 4b: err_clr held across a timeout keeps the flag clear
    ch_mask = 4'b0001; no_strobe = 1'b1; err_clr = 1'b1; s0 = samples.size();
    pulse_single();
    wait_idle(400);
    chk("t4b_prio", timeout_err, 0);
    chk("t4b_smp", samples[s0], 32'h1000);
    no_strobe = 1'b0; err_clr = 1'b0;

    // 5: scan_en dropped during CONVERT -> sample delivered, no scan_done
    ch_mask = 4'b0001; scan_en = 1'b1; s0 = samples.size(); d0 = n_done;
    wait_start(100);
    @(negedge hs_clk);
    scan_en = 1'b0;
    wait_idle(400);
    chk("t5_count", samples.size() - s0, 1);
    chk("t5_smp", samples[s0], 32'h0003);
    chk("t5_no_done", n_done - d0, 0);

    // 5b: reset in SETTLE
    ch_mask = 4'b0100; scan_en = 1'b1;
    repeat (3) @(negedge hs_clk);
    chk("t5b_settle", {busy, mux_valid, mux_sel}, {1'b1, 1'b0, 2'd2});
    sys_rst_n = 1'b0;
    @(negedge hs_clk);
    chk("t5b_rst_busy", busy, 0);
    chk("t5b_rst_mux", mux_sel, 0);
    chk("t5b_rst_outs", {mux_valid, adc_start, smp_valid, scan_done}, 0);
    scan_en = 1'b0; s0 = samples.size();
    sys_rst_n = 1'b1;
    repeat (30) @(negedge hs_clk);
    chk("t5b_no_smp", samples.size() - s0, 0);

`ifdef ADC_SCAN_AVG_EN
    // 6: average of 10,11,12,13 with error on the third conversion
    avg_mode = 1'b1; conv_idx = 0; ch_mask = 4'b0001; s0 = samples.size();
    pulse_single();
    wait_idle(400);
    chk("t6_count", samples.size() - s0, 1);
    chk("t6_smp", samples[s0], 32'h100B);
    avg_mode = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end
endmodule
